// File: rtl/power_sample_logger.sv
// Packs pairs of 16-bit power samples into 32-bit words and writes them into a RAM ring region.
// Optional: define POWER_SAMPLE_LOGGER_STOP_ON_FULL_EN to stop at DONE once DEPTH words are written.
module power_sample_logger #(
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = 30000,
  parameter int unsigned ADDR_W    = 15
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_s_valid,
  input  logic [15:0]       i_s_data,
  output logic              o_s_ready,
  input  logic              i_mem_grant,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [3:0]        o_mem_byteenable,
  output logic              o_mem_chipselect,
  output logic              o_mem_write,
  output logic [31:0]       o_mem_writedata,
  output logic              o_mem_clken,
  output logic [ADDR_W-1:0] o_wr_ptr,
  output logic [15:0]       o_word_count,
  output logic              o_busy,
  output logic              o_wrapped
);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(BASE_ADDR + DEPTH - 1);
  localparam logic [15:0]       DepthCnt = 16'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e              r_state, w_state_d;
  logic [15:0]         r_half, w_half_d;
  logic                r_half_valid, w_half_valid_d;
  logic [31:0]         r_pend_data, w_pend_data_d;
  logic [3:0]          r_pend_be, w_pend_be_d;
  logic                r_pend_valid, w_pend_valid_d;
  logic [ADDR_W-1:0]   r_wr_ptr, w_wr_ptr_d;
  logic [15:0]         r_word_count, w_word_count_d;
  logic                r_wrapped, w_wrapped_d;

  logic w_full;
  logic w_write_fire;
  logic w_s_ready;
  logic w_accept;

`ifdef POWER_SAMPLE_LOGGER_STOP_ON_FULL_EN
  assign w_full = (r_word_count == DepthCnt);
`else
  assign w_full = 1'b0;
`endif

  // Writes are suppressed in the reset cycle and once a stop-on-full ring is complete.
  assign w_write_fire = r_pend_valid & i_mem_grant & ~i_reset & ~w_full;
  assign w_s_ready    = (r_state == StRun) & ~(r_half_valid & r_pend_valid & ~w_write_fire) &
                        ~w_full & ~i_reset;
  assign w_accept     = i_s_valid & w_s_ready;

  always_comb begin
    w_state_d      = r_state;
    w_half_d       = r_half;
    w_half_valid_d = r_half_valid;
    w_pend_data_d  = r_pend_data;
    w_pend_be_d    = r_pend_be;
    w_pend_valid_d = r_pend_valid;
    w_wr_ptr_d     = r_wr_ptr;
    w_word_count_d = r_word_count;
    w_wrapped_d    = r_wrapped;

    if (w_write_fire) begin
      w_pend_valid_d = 1'b0;
      if (r_wr_ptr == LastAddr) begin
        w_wr_ptr_d = BaseAddr;
`ifndef POWER_SAMPLE_LOGGER_STOP_ON_FULL_EN
        w_wrapped_d = 1'b1;
`endif
      end else begin
        w_wr_ptr_d = r_wr_ptr + 1'b1;
      end
      if (r_word_count != DepthCnt) begin
        w_word_count_d = r_word_count + 16'd1;
      end
    end

    unique case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          w_state_d      = StRun;
          w_wr_ptr_d     = BaseAddr;
          w_word_count_d = 16'd0;
          w_wrapped_d    = 1'b0;
          w_half_valid_d = 1'b0;
          w_pend_valid_d = 1'b0;
        end
      end
      StRun: begin
        if (w_accept) begin
          if (!r_half_valid) begin
            w_half_d       = i_s_data;
            w_half_valid_d = 1'b1;
          end else begin
            w_pend_data_d  = {i_s_data, r_half};
            w_pend_be_d    = 4'b1111;
            w_pend_valid_d = 1'b1;
            w_half_valid_d = 1'b0;
          end
        end
        // With nothing left to drain, skip FLUSH entirely.
        if (i_stop) begin
          w_state_d = (!w_half_valid_d && !w_pend_valid_d) ? StIdle : StFlush;
        end
        if (w_full) begin
          w_state_d      = StDone;
          w_half_valid_d = 1'b0;
          w_pend_valid_d = 1'b0;
        end
      end
      StFlush: begin
        if (r_half_valid && (!r_pend_valid || w_write_fire)) begin
          w_pend_data_d  = {16'h0000, r_half};
          w_pend_be_d    = 4'b0011;
          w_pend_valid_d = 1'b1;
          w_half_valid_d = 1'b0;
        end
        if (!w_half_valid_d && !w_pend_valid_d) begin
          w_state_d = StIdle;
        end
        if (w_full) begin
          w_state_d      = StDone;
          w_half_valid_d = 1'b0;
          w_pend_valid_d = 1'b0;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_half       <= 16'h0000;
      r_half_valid <= 1'b0;
      r_pend_data  <= 32'h0000_0000;
      r_pend_be    <= 4'b0000;
      r_pend_valid <= 1'b0;
      r_wr_ptr     <= BaseAddr;
      r_word_count <= 16'd0;
      r_wrapped    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_half       <= w_half_d;
      r_half_valid <= w_half_valid_d;
      r_pend_data  <= w_pend_data_d;
      r_pend_be    <= w_pend_be_d;
      r_pend_valid <= w_pend_valid_d;
      r_wr_ptr     <= w_wr_ptr_d;
      r_word_count <= w_word_count_d;
      r_wrapped    <= w_wrapped_d;
    end
  end

  assign o_s_ready        = w_s_ready;
  assign o_mem_address    = r_wr_ptr;
  assign o_mem_byteenable = r_pend_be;
  assign o_mem_chipselect = w_write_fire;
  assign o_mem_write      = w_write_fire;
  assign o_mem_writedata  = r_pend_data;
  assign o_mem_clken      = 1'b1;
  assign o_wr_ptr         = r_wr_ptr;
  assign o_word_count     = r_word_count;
  assign o_busy           = (r_state == StRun) || (r_state == StFlush);
  assign o_wrapped        = r_wrapped;

endmodule

// File: tb/tb_power_sample_logger.sv
// Directed bench for power_sample_logger: expected RAM writes are queued as stimulus is driven
// and checked against every observed mem_write.
module tb_power_sample_logger;

  localparam int unsigned Base  = 10;
  localparam int unsigned Depth = 4;
  localparam int unsigned AddrW = 15;

  logic             clk;
  logic             reset;
  logic             start;
  logic             stop;
  logic             s_valid;
  logic [15:0]      s_data;
  logic             s_ready;
  logic             mem_grant;
  logic [AddrW-1:0] mem_address;
  logic [3:0]       mem_byteenable;
  logic             mem_chipselect;
  logic             mem_write;
  logic [31:0]      mem_writedata;
  logic             mem_clken;
  logic [AddrW-1:0] wr_ptr;
  logic [15:0]      word_count;
  logic             busy;
  logic             wrapped;

  typedef struct packed {
    logic [AddrW-1:0] a;
    logic [31:0]      d;
    logic [3:0]       be;
  } wr_t;

  wr_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  power_sample_logger #(
    .BASE_ADDR (Base),
    .DEPTH     (Depth),
    .ADDR_W    (AddrW)
  ) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_start          (start),
    .i_stop           (stop),
    .i_s_valid        (s_valid),
    .i_s_data         (s_data),
    .o_s_ready        (s_ready),
    .i_mem_grant      (mem_grant),
    .o_mem_address    (mem_address),
    .o_mem_byteenable (mem_byteenable),
    .o_mem_chipselect (mem_chipselect),
    .o_mem_write      (mem_write),
    .o_mem_writedata  (mem_writedata),
    .o_mem_clken      (mem_clken),
    .o_wr_ptr         (wr_ptr),
    .o_word_count     (word_count),
    .o_busy           (busy),
    .o_wrapped        (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int unsigned a, input logic [31:0] d, input logic [3:0] be);
    wr_t e;
    e.a  = AddrW'(a);
    e.d  = d;
    e.be = be;
    exp_q.push_back(e);
  endtask

  // Offer one sample and hold it until accepted, bounded by a cycle budget.
  task automatic send(input logic [15:0] d);
    logic acc;
    acc     = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int k = 0; k < 50; k++) begin
      #2;
      acc = s_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    s_valid = 1'b0;
    check("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40; k++) begin
      if (!busy) break;
      tick();
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_cs", 32'(mem_chipselect), 32'd0);
    check("rst_write", 32'(mem_write), 32'd0);
    check("rst_be", 32'(mem_byteenable), 32'd0);
    check("rst_wdata", mem_writedata, 32'd0);
    check("rst_addr", 32'(mem_address), Base);
    check("rst_wr_ptr", 32'(wr_ptr), Base);
    check("rst_count", 32'(word_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wrapped", 32'(wrapped), 32'd0);
    check("rst_clken", 32'(mem_clken), 32'd1);
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_write) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(mem_address), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_address), 32'(e.a));
        check("wr_data", mem_writedata, e.d);
        check("wr_be", 32'(mem_byteenable), 32'(e.be));
        check("wr_cs", 32'(mem_chipselect), 32'd1);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    s_valid   = 1'b0;
    s_data    = 16'h0000;
    mem_grant = 1'b0;
    tick();
    tick();
    check_reset_values();
    reset = 1'b0;
    tick();

    // Four samples, continuous grant: two full words.
    mem_grant = 1'b1;
    pulse_start();
    check("start_ready", 32'(s_ready), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    push(Base,     32'h0002_0001, 4'hF);
    push(Base + 1, 32'h0004_0003, 4'hF);
    send(16'h0001);
    send(16'h0002);
    check("latency_write", 32'(mem_write), 32'd1);
    send(16'h0003);
    send(16'h0004);
    tick();
    tick();
    check("t1_count", 32'(word_count), 32'd2);
    check("t1_ptr", 32'(wr_ptr), Base + 2);
    check("t1_drained", exp_q.size(), 32'd0);
    pulse_stop();
    check("t1_stop_idle", 32'(busy), 32'd0);

    // Odd sample count then stop: partial word flushed with low-half byteenable.
    pulse_start();
    push(Base,     32'h000B_000A, 4'hF);
    push(Base + 1, 32'h0000_000C, 4'b0011);
    send(16'h000A);
    send(16'h000B);
    send(16'h000C);
    pulse_stop();
    wait_idle();
    check("t2_count", 32'(word_count), 32'd2);
    check("t2_ptr", 32'(wr_ptr), Base + 2);
    check("t2_drained", exp_q.size(), 32'd0);

    // Back-pressure: no grant holds one word plus one half, then a single grant cycle.
    mem_grant = 1'b0;
    pulse_start();
    send(16'h0001);
    send(16'h0002);
    send(16'h0003);
    s_valid = 1'b1;
    s_data  = 16'h0004;
    #2;
    check("bp_ready_low", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    tick();
    check("bp_no_write", 32'(mem_write), 32'd0);
    check("bp_count", 32'(word_count), 32'd0);
    push(Base, 32'h0002_0001, 4'hF);
    mem_grant = 1'b1;
    tick();
    mem_grant = 1'b0;
    check("bp_ready_back", 32'(s_ready), 32'd1);
    check("bp_one_write", 32'(word_count), 32'd1);
    push(Base + 1, 32'h0000_0003, 4'b0011);
    mem_grant = 1'b1;
    pulse_stop();
    wait_idle();
    check("t3_drained", exp_q.size(), 32'd0);

    // Ring of four words.
    pulse_start();
`ifdef POWER_SAMPLE_LOGGER_STOP_ON_FULL_EN
    for (int k = 0; k < 4; k++) begin
      push(Base + k, {16'(2 * k + 2), 16'(2 * k + 1)}, 4'hF);
    end
    for (int k = 1; k <= 9; k++) begin
      send(16'(k));
    end
    tick();
    tick();
    check("full_busy", 32'(busy), 32'd0);
    check("full_ready", 32'(s_ready), 32'd0);
    check("full_count", 32'(word_count), 32'd4);
    check("full_wrapped", 32'(wrapped), 32'd0);
    check("full_drained", exp_q.size(), 32'd0);
    pulse_start();
    check("rearm_busy", 32'(busy), 32'd1);
    check("rearm_count", 32'(word_count), 32'd0);
    pulse_stop();
`else
    for (int k = 0; k < 5; k++) begin
      push(Base + (k % Depth), {16'(2 * k + 2), 16'(2 * k + 1)}, 4'hF);
    end
    for (int k = 1; k <= 10; k++) begin
      send(16'(k));
    end
    tick();
    tick();
    check("wrap_flag", 32'(wrapped), 32'd1);
    check("wrap_count_sat", 32'(word_count), 32'd4);
    check("wrap_ptr", 32'(wr_ptr), Base + 1);
    check("wrap_drained", exp_q.size(), 32'd0);
    pulse_stop();
`endif
    wait_idle();

    // Reset while a word is pending with grant high: no write, state discarded.
    mem_grant = 1'b0;
    pulse_start();
    send(16'h1111);
    send(16'h2222);
    mem_grant = 1'b1;
    reset     = 1'b1;
    #2;
    check("rst_mid_write", 32'(mem_write), 32'd0);
    check("rst_mid_cs", 32'(mem_chipselect), 32'd0);
    tick();
    check_reset_values();
    reset = 1'b0;
    tick();
    tick();
    tick();
    check("rst_discard", 32'(word_count), 32'd0);

    // Start and stop together in IDLE arms; stop with nothing buffered returns at once.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("ss_busy", 32'(busy), 32'd1);
    check("ss_ready", 32'(s_ready), 32'd1);
    pulse_stop();
    check("empty_stop_idle", 32'(busy), 32'd0);
    check("final_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/power_sample_logger.md
# power_sample_logger

Streaming write-side master that accepts 16-bit power-monitor samples over a valid/ready handshake, packs two samples per 32-bit word, and writes them into a circular region of the on-chip memory. It sits directly upstream of the 32-bit single-port on-chip RAM (15-bit word address, 30000 words) and drives that RAM's write port. The arbiter grants it access to the port when the processor is not using it.

## Interface
- BASE_ADDR, 0 — first word address of the ring region.
- DEPTH, 30000 — ring length in 32-bit words; BASE_ADDR+DEPTH ≤ 30000.
- ADDR_W, 15 — memory word-address width.
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; arms logger from IDLE or DONE.
- stop  in  1  pulse; ends capture, flushes partial word.
- s_valid  in  1  sample valid.
- s_data  in  16  sample value.
- s_ready  out  1  sample accepted when s_valid & s_ready.
- mem_grant  in  1  arbiter grants the memory port this cycle.
- mem_address  out  ADDR_W  RAM word address.
- mem_byteenable  out  4  RAM byte enables.
- mem_chipselect  out  1  RAM chip select.
- mem_write  out  1  RAM write strobe.
- mem_writedata  out  32  RAM write data.
- mem_clken  out  1  RAM clock enable; constant 1.
- wr_ptr  out  ADDR_W  next word address to write.
- word_count  out  16  words written since start, saturating at DEPTH.
- busy  out  1  state is RUN or FLUSH.
- wrapped  out  1  sticky; ring pointer has wrapped since start.

## Operation
- Storage:
  - half register: low sample plus half_valid.
  - pending register: word, byteenable, pending_valid.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE/DONE + start:
  - wr_ptr←BASE_ADDR, word_count←0, wrapped←0.
  - half_valid and pending_valid cleared.
  - Next state RUN.
- RUN, sample accepted:
  - If half_valid=0: the sample goes to the half register [15:0].
  - Else: pending←{s_data, half}, byteenable 4'b1111, half_valid←0.
- s_ready = (state==RUN) & !(half_valid & pending_valid & !write_fire).
- write_fire = pending_valid & mem_grant (combinational).
  - mem_chipselect = mem_write = write_fire.
  - mem_address = wr_ptr; mem_writedata and mem_byteenable come from the pending register.
- On write_fire:
  - pending_valid←0 unless reloaded the same cycle.
  - wr_ptr advances; BASE_ADDR+DEPTH-1 → BASE_ADDR with wrapped←1.
  - word_count increments, saturating at DEPTH.
- RUN + stop → FLUSH; samples are not accepted in FLUSH.
  - If half_valid: once pending is free, pending←{16'h0, half} with byteenable 4'b0011.
  - When half_valid=0 and pending_valid=0 → IDLE.
- start while RUN/FLUSH: ignored. stop while IDLE/DONE: ignored.
- start and stop in the same cycle: the rule for the current state applies.
- mem_grant low: the pending word is held unchanged indefinitely; s_ready drops once the half register is also occupied.

## Timing
- Reset values (next edge with reset=1):
  - State IDLE, s_ready 0, mem_chipselect 0, mem_write 0, mem_byteenable 0, mem_writedata 0.
  - mem_address = BASE_ADDR, wr_ptr BASE_ADDR, word_count 0, busy 0, wrapped 0, mem_clken 1.
- Reset mid-operation discards the half and pending data; no write is issued in the reset cycle.
- Latency: the second sample is accepted at edge N; write_fire can occur in cycle N+1 if mem_grant=1.
- The RAM write data is valid in the same cycle as mem_write.
- Sustained throughput: one sample per cycle with continuous grant.
- start→s_ready high: 1 cycle. stop→IDLE: 1 cycle minimum, plus flush writes.

## Configuration
- Macro: POWER_SAMPLE_LOGGER_STOP_ON_FULL_EN.
- Defined:
  - When word_count reaches DEPTH, the state goes to DONE the following cycle.
  - A pending full word still in flight is discarded; s_ready stays 0.
  - wrapped is never set.
  - start re-arms the logger.
- Undefined:
  - The ring overwrites the oldest data indefinitely and wrapped is set.
  - DONE is unreachable.

## Test plan
- Reset then start, 4 samples 16'h0001..16'h0004, mem_grant=1 → writes 32'h0002_0001 @BASE, 32'h0004_0003 @BASE+1, byteenable 4'hF, word_count=2.
- 3 samples 16'hA, 16'hB, 16'hC then stop → second write 32'h0000_000C byteenable 4'b0011 @BASE+1, return to IDLE, busy=0.
- mem_grant=0 with continuous s_valid → one word pending plus one half held, s_ready=0 after 3 accepts; grant=1 → exactly one write, s_ready high next cycle.
- DEPTH=4, 10 samples, macro undefined → addresses BASE..BASE+3 then BASE, wrapped=1, word_count=4. Macro defined → DONE after 4 writes, s_ready=0.
- Reset asserted with pending_valid=1 and mem_grant=1 → no mem_write that cycle, all outputs at reset values next cycle.
- start and stop in the same cycle in IDLE → RUN. stop in RUN with half empty and pending empty → IDLE next cycle.
